// File: rtl/spsram_fifo_ctrl.sv
// Synchronous FIFO controller in front of a single-port SRAM.
// Push writes and prefetch reads share the one SRAM port. A 2-entry output
// buffer hides the one-cycle registered read latency of the macro.
module spsram_fifo_ctrl #(
    parameter int D_WIDTH = 32,
    parameter int DEPTH   = 1024,
    parameter int A_WIDTH = 10
) (
    input  logic                 CK,
    input  logic                 RSTN,
    input  logic                 WR_VALID,
    output logic                 WR_READY,
    input  logic [D_WIDTH-1:0]   WR_DATA,
    output logic                 RD_VALID,
    input  logic                 RD_READY,
    output logic [D_WIDTH-1:0]   RD_DATA,
    output logic                 SRAM_CSN,
    output logic                 SRAM_WEN,
    output logic                 SRAM_OEN,
    output logic [A_WIDTH-1:0]   SRAM_A,
    output logic [D_WIDTH-1:0]   SRAM_BWEN,
    output logic [D_WIDTH-1:0]   SRAM_DI,
    input  logic [D_WIDTH-1:0]   SRAM_DOUT,
    output logic [A_WIDTH+1:0]   COUNT,
    output logic                 FULL,
    output logic                 EMPTY
);

    localparam logic [A_WIDTH:0]   DEPTH_CNT = (A_WIDTH+1)'(DEPTH);
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);

    logic [A_WIDTH-1:0] wr_ptr_reg;
    logic [A_WIDTH-1:0] rd_ptr_reg;
    logic [A_WIDTH:0]   sram_cnt_reg;
    logic               rd_infl_reg;
    logic [1:0]         ob_cnt_reg;
    logic               ob_head_reg;
    logic [D_WIDTH-1:0] obuf_reg [2];

    logic               sram_nonempty;
    logic               rd_need;
    logic               push;
    logic               pop;
    logic               rd_issue;
    logic [2:0]         ob_credit;
    logic               ob_tail;
    logic [A_WIDTH+1:0] occupancy;

    // Port arbitration, handshakes and status flags from registered state.
    always_comb begin
        sram_nonempty = (sram_cnt_reg != '0);
        // Reader would starve: nothing buffered, nothing in flight.
        rd_need       = sram_nonempty && (ob_cnt_reg == 2'd0) && !rd_infl_reg;
        WR_READY      = RSTN && (sram_cnt_reg < DEPTH_CNT) && !rd_need;
        RD_VALID      = RSTN && (ob_cnt_reg != 2'd0);
        push          = WR_VALID && WR_READY;
        pop           = RD_VALID && RD_READY;
        // Slots of the output buffer already spoken for after this cycle's pop.
        ob_credit     = {1'b0, ob_cnt_reg} + {2'b00, rd_infl_reg} - {2'b00, pop};
        rd_issue      = RSTN && (rd_need || (!push && sram_nonempty && (ob_credit <= 3'd1)));
        ob_tail       = ob_head_reg ^ ob_cnt_reg[0];

        SRAM_CSN      = !(push || rd_issue);
        SRAM_WEN      = !push;
        SRAM_OEN      = !rd_issue;
        SRAM_A        = push ? wr_ptr_reg : rd_ptr_reg;
        SRAM_BWEN     = '0;
        SRAM_DI       = WR_DATA;

        RD_DATA       = obuf_reg[ob_head_reg];
        occupancy     = (A_WIDTH+2)'(sram_cnt_reg) + (A_WIDTH+2)'(rd_infl_reg)
                      + (A_WIDTH+2)'(ob_cnt_reg);
        COUNT         = RSTN ? occupancy : '0;
        FULL          = RSTN && (sram_cnt_reg == DEPTH_CNT);
        EMPTY         = !RSTN || (occupancy == '0);
    end

    // SRAM pointers, occupancy and the read-in-flight flag.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            sram_cnt_reg <= '0;
            rd_infl_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_ADDR) ? '0 : wr_ptr_reg + A_WIDTH'(1);
            end
            if (rd_issue) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_ADDR) ? '0 : rd_ptr_reg + A_WIDTH'(1);
            end
            if (push) begin
                sram_cnt_reg <= sram_cnt_reg + (A_WIDTH+1)'(1);
            end else if (rd_issue) begin
                sram_cnt_reg <= sram_cnt_reg - (A_WIDTH+1)'(1);
            end
            rd_infl_reg <= rd_issue;
        end
    end

    // Output buffer bookkeeping: head moves on pop, count tracks pop vs capture.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            ob_cnt_reg  <= 2'd0;
            ob_head_reg <= 1'b0;
        end else begin
            if (pop) begin
                ob_head_reg <= ~ob_head_reg;
            end
            case ({rd_infl_reg, pop})
                2'b10:   ob_cnt_reg <= ob_cnt_reg + 2'd1;
                2'b01:   ob_cnt_reg <= ob_cnt_reg - 2'd1;
                default: ob_cnt_reg <= ob_cnt_reg;
            endcase
        end
    end

    // Capture returning SRAM data into the tail slot; a dropped read never lands.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_obuf
            always_ff @(posedge CK) begin
                if (RSTN && rd_infl_reg && (ob_tail == 1'(gi))) begin
                    obuf_reg[gi] <= SRAM_DOUT;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_spsram_fifo_ctrl.sv
// Self-checking bench for spsram_fifo_ctrl with a small non-power-of-two SRAM.
// A queue-based occupancy model is compared against the DUT every cycle, and
// directed sequences pin the model with hand-computed literal values.
module tb_spsram_fifo_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 5;
    localparam int AW    = 3;

    logic          CK       = 1'b0;
    logic          RSTN     = 1'b0;
    logic          WR_VALID = 1'b0;
    logic [DW-1:0] WR_DATA  = '0;
    logic          RD_READY = 1'b0;
    logic          WR_READY;
    logic          RD_VALID;
    logic [DW-1:0] RD_DATA;
    logic          SRAM_CSN;
    logic          SRAM_WEN;
    logic          SRAM_OEN;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_BWEN;
    logic [DW-1:0] SRAM_DI;
    logic [DW-1:0] sram_dout = '0;
    logic [AW+1:0] COUNT;
    logic          FULL;
    logic          EMPTY;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    spsram_fifo_ctrl #(
        .D_WIDTH (DW),
        .DEPTH   (DEPTH),
        .A_WIDTH (AW)
    ) dut (
        .CK        (CK),
        .RSTN      (RSTN),
        .WR_VALID  (WR_VALID),
        .WR_READY  (WR_READY),
        .WR_DATA   (WR_DATA),
        .RD_VALID  (RD_VALID),
        .RD_READY  (RD_READY),
        .RD_DATA   (RD_DATA),
        .SRAM_CSN  (SRAM_CSN),
        .SRAM_WEN  (SRAM_WEN),
        .SRAM_OEN  (SRAM_OEN),
        .SRAM_A    (SRAM_A),
        .SRAM_BWEN (SRAM_BWEN),
        .SRAM_DI   (SRAM_DI),
        .SRAM_DOUT (sram_dout),
        .COUNT     (COUNT),
        .FULL      (FULL),
        .EMPTY     (EMPTY)
    );

    // Behavioural single-port SRAM with registered read data.
    always @(posedge CK) begin
        if (!SRAM_CSN && !SRAM_WEN) mem[SRAM_A] <= SRAM_DI;
        if (!SRAM_CSN && !SRAM_OEN) sram_dout <= mem[SRAM_A];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, return mid-cycle.
    task automatic tick(input logic rst_n, input logic wv, input logic [DW-1:0] wd, input logic rr);
        @(posedge CK);
        #1;
        RSTN     = rst_n;
        WR_VALID = wv;
        WR_DATA  = wd;
        RD_READY = rr;
        @(negedge CK);
    endtask

    // Model: all held words in one ordered queue; only counts say where they live.
    logic [DW-1:0] mq [$];
    int m_sram = 0;
    int m_infl = 0;
    int m_ob   = 0;
    int m_wa   = 0;
    int m_ra   = 0;

    always @(negedge CK) begin
        bit need, wrdy, mpush, rv, mpop, issue;
        chk("wen_oen_excl", SRAM_WEN | SRAM_OEN, 1);
        chk("bwen", SRAM_BWEN, 0);
        if (!RSTN) begin
            chk("rst_wr_ready", WR_READY, 0);
            chk("rst_rd_valid", RD_VALID, 0);
            chk("rst_csn", SRAM_CSN, 1);
            chk("rst_wen", SRAM_WEN, 1);
            chk("rst_oen", SRAM_OEN, 1);
            chk("rst_count", COUNT, 0);
            chk("rst_full", FULL, 0);
            chk("rst_empty", EMPTY, 1);
            mq.delete();
            m_sram = 0; m_infl = 0; m_ob = 0; m_wa = 0; m_ra = 0;
        end else begin
            need  = (m_sram > 0) && (m_ob == 0) && (m_infl == 0);
            wrdy  = (m_sram < DEPTH) && !need;
            mpush = WR_VALID && wrdy;
            rv    = (m_ob > 0);
            mpop  = rv && RD_READY;
            issue = need || (!mpush && (m_sram > 0) && ((m_ob + m_infl - int'(mpop)) <= 1));
            chk("wr_ready", WR_READY, wrdy);
            chk("rd_valid", RD_VALID, rv);
            if (rv) chk("rd_data", RD_DATA, mq[0]);
            chk("count", COUNT, mq.size());
            chk("full", FULL, m_sram == DEPTH);
            chk("empty", EMPTY, mq.size() == 0);
            chk("csn", SRAM_CSN, !(mpush || issue));
            chk("wen", SRAM_WEN, !mpush);
            chk("oen", SRAM_OEN, !issue);
            if (mpush) begin
                chk("wr_addr", SRAM_A, m_wa);
                chk("sram_di", SRAM_DI, WR_DATA);
            end
            if (issue) chk("rd_addr", SRAM_A, m_ra);
            if (mpop) begin
                void'(mq.pop_front());
                m_ob--;
            end
            if (m_infl != 0) m_ob++;
            m_infl = issue ? 1 : 0;
            if (issue) begin
                m_sram--;
                m_ra = (m_ra + 1) % DEPTH;
            end
            if (mpush) begin
                mq.push_back(WR_DATA);
                m_sram++;
                m_wa = (m_wa + 1) % DEPTH;
            end
        end
    end

    task automatic do_reset();
        tick(1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b0);
        chk("reset_empty", EMPTY, 1);
        chk("reset_wr_ready", WR_READY, 0);
    endtask

    // Pop until empty with a bounded cycle budget.
    task automatic drain(input string name);
        for (int i = 0; i < 40 && !EMPTY; i++) tick(1'b1, 1'b0, '0, 1'b1);
        chk(name, EMPTY, 1);
        tick(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int popped;

        // First word latency from empty.
        do_reset();
        tick(1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
        chk("t1_c0_wr_ready", WR_READY, 1);
        chk("t1_c0_wen", SRAM_WEN, 0);
        chk("t1_c0_addr", SRAM_A, 0);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("t1_c1_oen", SRAM_OEN, 0);
        chk("t1_c1_addr", SRAM_A, 0);
        chk("t1_c1_count", COUNT, 1);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("t1_c2_rd_valid", RD_VALID, 0);
        chk("t1_c2_count", COUNT, 1);
        tick(1'b1, 1'b0, '0, 1'b1);
        chk("t1_c3_rd_valid", RD_VALID, 1);
        chk("t1_c3_rd_data", RD_DATA, 32'hA5A5_0001);
        chk("t1_c3_count", COUNT, 1);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("t1_empty_after_pop", EMPTY, 1);

        // Fill to capacity with the reader stalled, then drain in order.
        do_reset();
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 1'b1, DW'(acc), 1'b0);
            if (WR_READY) acc++;
        end
        chk("fill_accepted", acc, DEPTH + 2);
        chk("fill_wr_ready", WR_READY, 0);
        chk("fill_full", FULL, 1);
        chk("fill_count", COUNT, DEPTH + 2);
        popped = 0;
        for (int i = 0; i < 40 && !EMPTY; i++) begin
            tick(1'b1, 1'b0, '0, 1'b1);
            if (RD_VALID) begin
                chk("drain_data", RD_DATA, popped);
                popped++;
            end
        end
        chk("drain_popped", popped, DEPTH + 2);
        chk("drain_empty", EMPTY, 1);

        // Address wrap over a non-power-of-two depth.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b1, DW'(32'h100 + k), 1'b0);
            chk("wrap_wen", SRAM_WEN, 0);
            chk("wrap_wr_addr", SRAM_A, k % DEPTH);
            tick(1'b1, 1'b0, '0, 1'b0);
            chk("wrap_oen", SRAM_OEN, 0);
            chk("wrap_rd_addr", SRAM_A, k % DEPTH);
            tick(1'b1, 1'b0, '0, 1'b0);
            tick(1'b1, 1'b0, '0, 1'b1);
            chk("wrap_rd_valid", RD_VALID, 1);
            chk("wrap_rd_data", RD_DATA, 32'h100 + k);
        end

        // Reader stall holds the head word.
        do_reset();
        acc = 0;
        for (int i = 0; i < 12 && acc < 3; i++) begin
            tick(1'b1, 1'b1, DW'(32'h51 + acc), 1'b0);
            if (WR_READY) acc++;
        end
        chk("stall_accepted", acc, 3);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            chk("stall_valid", RD_VALID, 1);
            chk("stall_hold", RD_DATA, 32'h51);
        end
        tick(1'b1, 1'b0, '0, 1'b1);
        chk("stall_release", RD_DATA, 32'h51);
        tick(1'b1, 1'b0, '0, 1'b1);
        chk("stall_next_valid", RD_VALID, 1);
        chk("stall_next", RD_DATA, 32'h52);
        drain("stall_drain_empty");

        // Reset while a read is in flight drops it.
        do_reset();
        tick(1'b1, 1'b1, 32'h77, 1'b0);
        chk("rif_push", WR_READY, 1);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("rif_issue", SRAM_OEN, 0);
        tick(1'b0, 1'b0, '0, 1'b0);
        chk("rif_rst_empty", EMPTY, 1);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("rif_no_capture_valid", RD_VALID, 0);
        chk("rif_no_capture_empty", EMPTY, 1);
        chk("rif_no_capture_count", COUNT, 0);
        tick(1'b1, 1'b1, 32'h0000_00FF, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("rif_c2_valid", RD_VALID, 0);
        tick(1'b1, 1'b0, '0, 1'b1);
        chk("rif_c3_valid", RD_VALID, 1);
        chk("rif_c3_data", RD_DATA, 32'h0000_00FF);
        tick(1'b1, 1'b0, '0, 1'b0);

        // Random concurrent traffic; the per-cycle model does the checking.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        drain("random_drain_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
